sm_mdu: RTL and testbench

Iterative multiply/divide unit and its sequencer for the schoolMIPS core. It accepts one MULTU/DIVU request at a time and runs a 32-step radix-2 shift-add or restoring-divide loop. While the loop runs it holds `busy` high so the core stalls its PC. Results land in internal HI/LO registers, which the core reads for MFHI/MFLO.

---
 rtl/sm_mdu.sv | 166 ++++++++++++++++
 tb/tb_sm_mdu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_mdu.sv
// sm_mdu: iterative 32-bit multiply/divide unit for the schoolMIPS core.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over
// 32 cycles. Results go to HI/LO only when an operation completes.
// Optional feature macro: SM_CONFIG_MDU_SIGNED_EN (signed MULT/DIV via op[1]).
module sm_mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic        isDiv;
  logic [31:0] accHi;
  logic [31:0] accLo;
  logic [31:0] opB;

  logic        accept;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] mulAddend;
  logic [32:0] mulSum;
  logic [32:0] divShift;
  logic [31:0] divDiff;
  logic        divGe;
  logic [31:0] nextHi;
  logic [31:0] nextLo;
  logic [31:0] finHi;
  logic [31:0] finLo;

  // A new request is only taken outside RUN, and cancel always blocks it.
  assign accept = (state != RUN) && start && !cancel;

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef SM_CONFIG_MDU_SIGNED_EN
  logic        signedReq;
  logic        negRes;
  logic        negRem;
  logic [63:0] prodNeg;

  // The loop always works on magnitudes; signs are remembered separately.
  assign signedReq = op[1];
  assign magA      = (signedReq && srcA[31]) ? -srcA : srcA;
  assign magB      = (signedReq && srcB[31]) ? -srcB : srcB;
  assign prodNeg   = 64'd0 - {nextHi, nextLo};

  // Capture result and remainder signs when the operation is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negRes <= 1'b0;
      negRem <= 1'b0;
    end else if (accept) begin
      negRes <= signedReq & (srcA[31] ^ srcB[31]);
      negRem <= signedReq & op[0] & srcA[31];
    end
  end

  // Apply the sign fix-up to the final iteration's magnitude result.
  always_comb begin
    finHi = nextHi;
    finLo = nextLo;
    if (isDiv) begin
      if (negRes) finLo = -nextLo;
      if (negRem) finHi = -nextHi;
    end else if (negRes) begin
      finHi = prodNeg[63:32];
      finLo = prodNeg[31:0];
    end
  end
`else
  logic unusedOpSign;

  // Unsigned-only build: the sign request bit has no effect.
  assign unusedOpSign = op[1];
  assign magA         = srcA;
  assign magB         = srcB;
  assign finHi        = nextHi;
  assign finLo        = nextLo;
`endif

  // One iteration of either the shift-add multiply or the restoring divide.
  always_comb begin
    mulAddend = accLo[0] ? opB : 32'd0;
    mulSum    = {1'b0, accHi} + {1'b0, mulAddend};
    divShift  = {accHi, accLo[31]};
    divDiff   = divShift[31:0] - opB;
    divGe     = (divShift >= {1'b0, opB});
    if (isDiv) begin
      nextHi = divGe ? divDiff : divShift[31:0];
      nextLo = {accLo[30:0], divGe};
    end else begin
      nextHi = mulSum[32:1];
      nextLo = {mulSum[0], accLo[31:1]};
    end
  end

  // Sequencer: IDLE/DONE accept requests, RUN counts 32 iterations down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 5'd0;
    end else if (cancel) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            count <= 5'd31;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (count == 5'd0) state <= DONE;
          else               count <= count - 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Working registers: loaded with operands on accept, stepped in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accHi <= 32'd0;
      accLo <= 32'd0;
      opB   <= 32'd0;
      isDiv <= 1'b0;
    end else if (accept) begin
      accHi <= 32'd0;
      accLo <= magA;
      opB   <= magB;
      isDiv <= op[0];
    end else if (state == RUN) begin
      accHi <= nextHi;
      accLo <= nextLo;
    end
  end

  // HI/LO update only on the last iteration of an uncancelled run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if ((state == RUN) && (count == 5'd0) && !cancel) begin
      hi <= finHi;
      lo <= finLo;
    end
  end

endmodule

// File: tb/tb_sm_mdu.sv
// tb_sm_mdu: self-checking bench for sm_mdu. Directed vector table,
// multi-cycle corner sequences (cancel, back-to-back, async reset) and
// random operations checked against an arithmetic reference model.
module tb_sm_mdu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          errors;
  logic [31:0] expHi;
  logic [31:0] expLo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vecT;

  vecT vecs[10];

  sm_mdu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .srcA   (srcA),
    .srcB   (srcB),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result {hi, lo} from plain arithmetic on the operation rules.
  function automatic logic [63:0] modelOp(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic isSigned;
    int   q;
    int   r;
`ifdef SM_CONFIG_MDU_SIGNED_EN
    isSigned = o[1];
`else
    isSigned = 1'b0;
`endif
    if (!o[0]) begin
      if (isSigned) return longint'($signed(a)) * longint'($signed(b));
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) return {a, (isSigned && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF};
    if (isSigned) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Single comparison; counts it and reports on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  // Issue one request at a negedge and follow it until done (bounded).
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int hold,
                               output int latency, output int busyCnt);
    start   = 1'b1;
    op      = o;
    srcA    = a;
    srcB    = b;
    latency = 0;
    busyCnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == hold) begin
        start = 1'b0;
        srcA  = ~a;
        srcB  = ~b;
      end
      if (done) begin
        latency = c;
        break;
      end
      if (busy) busyCnt++;
      if (c == 16) checkOutput("hiLoHeldMidRun", {hi, lo}, {expHi, expLo});
    end
    start = 1'b0;
  endtask

  // Run one operation and check timing plus the final HI/LO values.
  task automatic runAndCheck(input string name, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eHi, input logic [31:0] eLo,
                             input int hold);
    int latency;
    int busyCnt;
    applyStimulus(o, a, b, hold, latency, busyCnt);
    checkOutput({name, "_latency"}, 64'(latency), 64'd33);
    checkOutput({name, "_busyCycles"}, 64'(busyCnt), 64'd32);
    checkOutput({name, "_busyInDone"}, 64'(busy), 64'd0);
    checkOutput({name, "_result"}, {hi, lo}, {eHi, eLo});
    expHi = eHi;
    expLo = eLo;
  endtask

  initial begin
    int doneSeen;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] m;

    checks = 0;
    errors = 0;
    expHi  = 32'd0;
    expLo  = 32'd0;
    rst_n  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 2'b00;
    srcA   = 32'd0;
    srcB   = 32'd0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b01, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[2] = '{2'b01, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF};
    vecs[3] = '{2'b00, 32'd3, 32'd5, 32'd0, 32'd15};
    vecs[8] = '{2'b01, 32'd5, 32'd9, 32'd5, 32'd0};
    vecs[9] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF};
`ifdef SM_CONFIG_MDU_SIGNED_EN
    vecs[4] = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{2'b10, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
    vecs[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    vecs[7] = '{2'b11, 32'h8000_0003, 32'd0, 32'h8000_0003, 32'h0000_0001};
`else
    vecs[4] = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC};
    vecs[5] = '{2'b10, 32'hFFFF_FFFD, 32'd4, 32'd3, 32'hFFFF_FFF4};
    vecs[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    vecs[7] = '{2'b11, 32'h8000_0003, 32'd0, 32'h8000_0003, 32'hFFFF_FFFF};
`endif

    // Reset values appear without any clock edge.
    #1;
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetHiLo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idleAfterReset", {62'd0, busy, done}, 64'd0);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].expHi, vecs[i].expLo, 1);
      @(negedge clk);
      checkOutput("donePulseWidth", {62'd0, busy, done}, 64'd0);
    end

    // Start held well into RUN must not restart the operation.
    runAndCheck("heldStart", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 8);
    @(negedge clk);

    // Complete 3 x 5, then cancel a divide on RUN cycle 10 with start still high.
    runAndCheck("preCancel", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    srcA  = 32'd1000;
    srcB  = 32'd3;
    for (int c = 1; c <= 9; c++) @(negedge clk);
    checkOutput("busyBeforeCancel", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    start  = 1'b0;
    checkOutput("cancelBusy", 64'(busy), 64'd0);
    checkOutput("cancelDone", 64'(done), 64'd0);
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkOutput("cancelNoDone", 64'(doneSeen), 64'd0);
    checkOutput("cancelHiLo", {hi, lo}, {32'd0, 32'd15});

    // Back-to-back: the divide starts in the DONE cycle of the multiply.
    runAndCheck("b2bFirst", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1);
    runAndCheck("b2bDiv", 2'b01, 32'd9, 32'd2, 32'd1, 32'd4, 1);
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    op    = 2'b00;
    srcA  = 32'h1234_5678;
    srcB  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstBusy", 64'(busy), 64'd0);
    checkOutput("asyncRstDone", 64'(done), 64'd0);
    checkOutput("asyncRstHiLo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expHi = 32'd0;
    expLo = 32'd0;
    @(negedge clk);
    runAndCheck("afterRst", 2'b01, 32'd1000, 32'd3, 32'd1, 32'd333, 1);
    @(negedge clk);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      m  = modelOp(ro, ra, rb);
      runAndCheck($sformatf("rand%0d", i), ro, ra, rb, m[63:32], m[31:0], 1);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
